mem_arbiter_fsm: RTL and testbench

- Arbitrates one single-ported RAM between two requesters: instruction fetch (i-side) and load/store (d-side).
- Sits between the datapath request signals and the RAM model.
- Sequences each access with a grant state machine, holds the requester in wait until the RAM reports completion, and enforces an anti-starvation rule for the i-side.

---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/mem_arbiter_fsm_starve_counter.sv | 32 +++
 rtl/mem_arbiter_fsm.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter_fsm.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg : shared RAM/arbiter types for the memory arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2
  } arb_state_t;

  localparam int STARVE_MAX_DEFAULT = 4;

  // ACCESS and ERROR both end the current RAM transaction.
  function automatic logic ram_finished(input logic [1:0] rs);
    return (rs == ACCESS) || (rs == ERROR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_fsm_starve_counter.sv
// ============================================================================
// starve_counter : saturating counter of d-side wins over a pending i-side
// Rev 1.0
// ============================================================================
`default_nettype none

module starve_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

  assign sat = (count == W'(MAX));

endmodule

`default_nettype wire

// File: rtl/mem_arbiter_fsm.sv
// ============================================================================
// mem_arbiter_fsm : i-side / d-side arbiter for a single-ported RAM
// Optional statistics counters enabled by MEM_ARB_STATS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter_fsm
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_err
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       i_grants,
  output logic [31:0]       d_grants,
  output logic [31:0]       stall_cycles
`endif
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_D_ACC = D_ACC;
  localparam logic [1:0] ST_I_ACC = I_ACC;

  logic [1:0] state;
  logic [1:0] next_state;
  logic       d_req;
  logic       i_done;
  logic       d_done;
  logic       starve_sat;

  assign d_req = dREN | dWEN;

  // Nothing is driven or acknowledged while RST is high.
  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    if (!RST) begin
      case (state)
        ST_IDLE: begin
          if (d_req && !(iREN && starve_sat)) begin
            next_state = ST_D_ACC;
          end else if (iREN) begin
            next_state = ST_I_ACC;
          end
        end
        ST_D_ACC: begin
          if (!d_req) begin
            next_state = ST_IDLE;
          end else begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            if (ram_finished(ramstate)) begin
              d_done     = 1'b1;
              next_state = ST_IDLE;
            end
          end
        end
        ST_I_ACC: begin
          if (!iREN) begin
            next_state = ST_IDLE;
          end else begin
            ramaddr = iaddr;
            ramREN  = 1'b1;
            if (ram_finished(ramstate)) begin
              i_done     = 1'b1;
              next_state = ST_IDLE;
            end
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  assign iwait = iREN  & ~i_done;
  assign dwait = d_req & ~d_done;
  assign iload = i_done ? ramload : '0;
  assign dload = d_done ? ramload : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      mem_err <= 1'b0;
    end else begin
      state <= next_state;
      if ((i_done || d_done) && (ramstate == ERROR)) begin
        mem_err <= 1'b1;
      end
    end
  end

  starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk (CLK),
    .rst (RST),
    .inc (d_done & iREN),
    .clr (i_done | ((state == ST_IDLE) & ~iREN)),
    .sat (starve_sat)
  );

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      i_grants     <= '0;
      d_grants     <= '0;
      stall_cycles <= '0;
    end else begin
      if ((state == ST_IDLE) && (next_state == ST_I_ACC) && (i_grants != '1)) begin
        i_grants <= i_grants + 1'b1;
      end
      if ((state == ST_IDLE) && (next_state == ST_D_ACC) && (d_grants != '1)) begin
        d_grants <= d_grants + 1'b1;
      end
      if ((iwait || dwait) && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter_fsm.sv
// ============================================================================
// tb_mem_arbiter_fsm : per-cycle vector table plus a starvation sequence
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter_fsm;

  localparam logic [1:0] FR = 2'd0;
  localparam logic [1:0] BZ = 2'd1;
  localparam logic [1:0] AC = 2'd2;
  localparam logic [1:0] ER = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        iren, dren, dwen;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramren, ramwen, mem_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter_fsm dut (
    .CLK      (clk),
    .RST      (rst),
    .iREN     (iren),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dren),
    .dWEN     (dwen),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramren),
    .ramWEN   (ramwen),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .mem_err  (mem_err)
  );

  typedef struct {
    logic        rst, iren, dren, dwen;
    logic [31:0] iaddr, daddr, dstore, rload;
    logic [1:0]  rs;
    logic        e_iw, e_dw, e_ren, e_wen, e_err;
    logic [31:0] e_il, e_dl, e_addr, e_store;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [31:0] da,
                     input logic [31:0] ds, input logic [1:0] s, input logic [31:0] rl,
                     input logic iw, input logic [31:0] il, input logic dwt,
                     input logic [31:0] dl, input logic ren, input logic wen,
                     input logic [31:0] ad, input logic [31:0] st, input logic er);
    vec_t v;
    v.rst = r; v.iren = ir; v.iaddr = ia; v.dren = dr; v.dwen = dw;
    v.daddr = da; v.dstore = ds; v.rs = s; v.rload = rl;
    v.e_iw = iw; v.e_il = il; v.e_dw = dwt; v.e_dl = dl; v.e_ren = ren;
    v.e_wen = wen; v.e_addr = ad; v.e_store = st; v.e_err = er;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  task automatic idle_vec(input logic er);
    add(0, 0, 0, 0, 0, 0, 0, FR, 0, 0, 0, 0, 0, 0, 0, 0, 0, er);
  endtask

  initial begin
    int d_seen;
    bit i_seen;

    rst = 1'b1; iren = 0; dren = 0; dwen = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FR;

    // reset: waits follow requests, nothing acknowledged
    add(1, 0, 0, 0, 0, 0, 0, FR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0, AC, 32'h1234, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    // i-only read
    add(0, 1, 32'h100, 0, 0, 0, 0, AC, 32'h00A00093, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 32'h100, 0, 0, 0, 0, AC, 32'h00A00093, 0, 32'h00A00093, 0, 0, 1, 0, 32'h100, 0, 0);
    idle_vec(0);
    // simultaneous: d first, then i
    add(0, 1, 32'h104, 1, 0, 32'h200, 0, AC, 32'h11111111, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 32'h104, 1, 0, 32'h200, 0, AC, 32'h11111111, 1, 0, 0, 32'h11111111, 1, 0, 32'h200, 0, 0);
    add(0, 1, 32'h104, 0, 0, 32'h200, 0, AC, 32'h11111111, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 32'h104, 0, 0, 32'h200, 0, AC, 32'h11111111, 0, 32'h11111111, 0, 0, 1, 0, 32'h104, 0, 0);
    idle_vec(0);
    // write with three BUSY wait states
    add(0, 0, 0, 0, 1, 32'h300, 32'hDEADBEEF, BZ, 32'h5A5A5A5A, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      add(0, 0, 0, 0, 1, 32'h300, 32'hDEADBEEF, BZ, 32'h5A5A5A5A, 0, 0, 1, 0, 0, 1, 32'h300, 32'hDEADBEEF, 0);
    add(0, 0, 0, 0, 1, 32'h300, 32'hDEADBEEF, AC, 32'h5A5A5A5A, 0, 0, 0, 32'h5A5A5A5A, 0, 1, 32'h300, 32'hDEADBEEF, 0);
    // read+write together (write wins), then abort
    add(0, 0, 0, 1, 1, 32'h304, 32'h1234, BZ, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 32'h304, 32'h1234, BZ, 0, 0, 0, 1, 0, 0, 1, 32'h304, 32'h1234, 0);
    add(0, 0, 0, 0, 0, 32'h304, 32'h1234, AC, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 32'h308, 0, AC, 32'h77, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 32'h308, 0, AC, 32'h77, 0, 0, 0, 32'h77, 1, 0, 32'h308, 0, 0);
    // ERROR on i-access: sticky mem_err
    add(0, 1, 32'h400, 0, 0, 0, 0, ER, 32'hBAD, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 32'h400, 0, 0, 0, 0, ER, 32'hBAD, 0, 32'hBAD, 0, 0, 1, 0, 32'h400, 0, 0);
    idle_vec(1);
    idle_vec(1);
    // reset during a stalled i-access
    add(0, 1, 32'h500, 0, 0, 0, 0, BZ, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 32'h500, 0, 0, 0, 0, BZ, 0, 1, 0, 0, 0, 1, 0, 32'h500, 0, 1);
    add(1, 1, 32'h500, 0, 0, 0, 0, BZ, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 32'h500, 0, 0, 0, 0, AC, 32'h42, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 32'h500, 0, 0, 0, 0, AC, 32'h42, 0, 32'h42, 0, 0, 1, 0, 32'h500, 0, 0);
    // starvation: four d wins, then i forced, then d again
    for (int k = 0; k < 4; k++) begin
      add(0, 1, 32'h600, 1, 0, 32'h700, 0, AC, 32'hCAFE0000, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 1, 32'h600, 1, 0, 32'h700, 0, AC, 32'hCAFE0000, 1, 0, 0, 32'hCAFE0000, 1, 0, 32'h700, 0, 0);
    end
    add(0, 1, 32'h600, 1, 0, 32'h700, 0, AC, 32'hCAFE0000, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 32'h600, 1, 0, 32'h700, 0, AC, 32'hCAFE0000, 0, 32'hCAFE0000, 1, 0, 1, 0, 32'h600, 0, 0);
    add(0, 1, 32'h600, 1, 0, 32'h700, 0, AC, 32'hCAFE0000, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 32'h600, 1, 0, 32'h700, 0, AC, 32'hCAFE0000, 1, 0, 0, 32'hCAFE0000, 1, 0, 32'h700, 0, 0);
    idle_vec(0);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; iren = vecs[i].iren; iaddr = vecs[i].iaddr;
      dren = vecs[i].dren; dwen = vecs[i].dwen; daddr = vecs[i].daddr;
      dstore = vecs[i].dstore; ramstate = vecs[i].rs; ramload = vecs[i].rload;
      #1;
      chk("iwait",    i, 32'(iwait),   32'(vecs[i].e_iw));
      chk("iload",    i, iload,        vecs[i].e_il);
      chk("dwait",    i, 32'(dwait),   32'(vecs[i].e_dw));
      chk("dload",    i, dload,        vecs[i].e_dl);
      chk("ramREN",   i, 32'(ramren),  32'(vecs[i].e_ren));
      chk("ramWEN",   i, 32'(ramwen),  32'(vecs[i].e_wen));
      chk("ramaddr",  i, ramaddr,      vecs[i].e_addr);
      chk("ramstore", i, ramstore,     vecs[i].e_store);
      chk("mem_err",  i, 32'(mem_err), 32'(vecs[i].e_err));
    end

    // continuous contention from idle: count d completions before i gets through
    d_seen = 0;
    i_seen = 1'b0;
    for (int c = 0; c < 40 && !i_seen; c++) begin
      @(negedge clk);
      rst = 0; iren = 1; iaddr = 32'h800; dren = 1; dwen = 0;
      daddr = 32'h900; dstore = 0; ramstate = AC; ramload = 32'h5;
      #1;
      if (!dwait) d_seen++;
      if (!iwait) i_seen = 1'b1;
    end
    chk("starve_i_granted", -1, 32'(i_seen), 32'd1);
    chk("starve_d_count",   -1, 32'(d_seen), 32'd4);

    @(negedge clk);
    iren = 0; dren = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
